exe_mem_stage: RTL and testbench

- Execute stage plus EX/MEM pipeline register. Sits directly downstream of the ID/EXE register and consumes its outputs.
- Applies MEM/WB forwarding to the operands, decodes ALU_OP/func, and computes the ALU result.
- Runs an iterative signed multiplier into HI/LO, stalling upstream while it runs.
- Registers the result and the memory/writeback controls for the MEM stage.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/exe_mem_stage_if.sv | 52 +++++
 rtl/mult_iter.sv | 91 +++++++++
 rtl/exe_mem_stage.sv | 154 +++++++++++++++
 tb/tb_exe_mem_stage.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: ALU_OP classes, R-type funct codes and the
// multiplier FSM state type used by the execute stage.
package mips_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MFLO = 6'h12;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mult_state_t;

endpackage

// File: rtl/exe_mem_stage_if.sv
// ID/EXE-to-EX/MEM bundle: operands, controls and forwarding sources in,
// registered EX/MEM fields and the combinational stall out.
interface exe_mem_stage_if;
  import mips_pkg::*;

  logic              flush;
  logic [DATA_W-1:0] val1_in;
  logic [DATA_W-1:0] val2_in;
  logic [DATA_W-1:0] st_value_in;
  logic [4:0]        src1_in;
  logic [4:0]        src2_in;
  logic [4:0]        dest_in;
  logic [1:0]        alu_op_in;
  logic [5:0]        func_in;
  logic              mem_r_en_in;
  logic              mem_w_en_in;
  logic              wb_en_in;
  logic              memtoreg_in;
  logic              val2_is_reg_in;
  logic              mem_fwd_wb_en;
  logic [4:0]        mem_fwd_dest;
  logic [DATA_W-1:0] mem_fwd_value;
  logic              wb_fwd_wb_en;
  logic [4:0]        wb_fwd_dest;
  logic [DATA_W-1:0] wb_fwd_value;

  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] st_value;
  logic [4:0]        dest;
  logic              mem_r_en;
  logic              mem_w_en;
  logic              wb_en;
  logic              memtoreg;
  logic              stall;

  modport slave (
    input  flush, val1_in, val2_in, st_value_in, src1_in, src2_in, dest_in,
           alu_op_in, func_in, mem_r_en_in, mem_w_en_in, wb_en_in, memtoreg_in,
           val2_is_reg_in, mem_fwd_wb_en, mem_fwd_dest, mem_fwd_value,
           wb_fwd_wb_en, wb_fwd_dest, wb_fwd_value,
    output alu_result, st_value, dest, mem_r_en, mem_w_en, wb_en, memtoreg, stall
  );

  modport master (
    output flush, val1_in, val2_in, st_value_in, src1_in, src2_in, dest_in,
           alu_op_in, func_in, mem_r_en_in, mem_w_en_in, wb_en_in, memtoreg_in,
           val2_is_reg_in, mem_fwd_wb_en, mem_fwd_dest, mem_fwd_value,
           wb_fwd_wb_en, wb_fwd_dest, wb_fwd_value,
    input  alu_result, st_value, dest, mem_r_en, mem_w_en, wb_en, memtoreg, stall
  );

endinterface

// File: rtl/mult_iter.sv
// Iterative signed multiplier: magnitudes are multiplied by shift-add, one
// partial product per cycle, and the sign is re-applied on the final product.
module mult_iter
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          abort_i,
  input  logic                          start_i,
  input  logic signed [MULT_CYCLES-1:0] a_i,
  input  logic signed [MULT_CYCLES-1:0] b_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic        [MULT_CYCLES-1:0] hi_o,
  output logic        [MULT_CYCLES-1:0] lo_o
);

  localparam int W     = MULT_CYCLES;
  localparam int CNT_W = $clog2(MULT_CYCLES);

  mult_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [2*W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic             neg_q, neg_d;
  logic [W-1:0]     a_mag, b_mag;
  logic [2*W-1:0]   prod;

  // -2^31 negates to itself, which read unsigned is exactly 2^31
  assign a_mag = a_i[W-1] ? -a_i : a_i;
  assign b_mag = b_i[W-1] ? -b_i : b_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          mcand_d  = {{W{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          neg_d    = a_i[W-1] ^ b_i[W-1];
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MULT_CYCLES - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i) state_d = IDLE;
  end

  assign prod   = neg_q ? -acc_q : acc_q;
  assign hi_o   = prod[2*W-1:W];
  assign lo_o   = prod[W-1:0];
  assign busy_o = (state_q == BUSY);
  assign done_o = (state_q == DONE);

endmodule

// File: rtl/exe_mem_stage.sv
// Execute stage with operand forwarding, ALU and the EX/MEM pipeline register.
// Define EXE_MULT_EN to build the iterative multiplier with HI/LO (mult/mfhi/mflo).
module exe_mem_stage
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  exe_mem_stage_if.slave   bus
);

  localparam int W = MULT_CYCLES;

  function automatic logic [W-1:0] fwd(
    input logic [4:0]   src,
    input logic [W-1:0] id_val,
    input logic         m_en,
    input logic [4:0]   m_dest,
    input logic [W-1:0] m_val,
    input logic         w_en,
    input logic [4:0]   w_dest,
    input logic [W-1:0] w_val
  );
    if (m_en && (m_dest == src) && (src != 5'd0))      return m_val;
    else if (w_en && (w_dest == src) && (src != 5'd0)) return w_val;
    else                                               return id_val;
  endfunction

  logic signed [W-1:0] op_a, op_b;
  logic        [W-1:0] st_fwd;
  logic        [W-1:0] res;
  logic                bubble;
  logic                stall;

  logic [W-1:0] alu_result_q, st_value_q;
  logic [4:0]   dest_q;
  logic         mem_r_en_q, mem_w_en_q, wb_en_q, memtoreg_q;

  always_comb begin
    op_a   = fwd(bus.src1_in, bus.val1_in, bus.mem_fwd_wb_en, bus.mem_fwd_dest,
                 bus.mem_fwd_value, bus.wb_fwd_wb_en, bus.wb_fwd_dest, bus.wb_fwd_value);
    st_fwd = fwd(bus.src2_in, bus.st_value_in, bus.mem_fwd_wb_en, bus.mem_fwd_dest,
                 bus.mem_fwd_value, bus.wb_fwd_wb_en, bus.wb_fwd_dest, bus.wb_fwd_value);
    // An immediate in val2 shares the rt field with a real register, so gate on val2_is_reg
    if (bus.val2_is_reg_in)
      op_b = fwd(bus.src2_in, bus.val2_in, bus.mem_fwd_wb_en, bus.mem_fwd_dest,
                 bus.mem_fwd_value, bus.wb_fwd_wb_en, bus.wb_fwd_dest, bus.wb_fwd_value);
    else
      op_b = bus.val2_in;
  end

`ifdef EXE_MULT_EN
  logic         is_mult, mult_start, mult_busy, mult_done;
  logic [W-1:0] mult_hi, mult_lo;
  logic [W-1:0] hi_q, lo_q;

  assign is_mult    = (bus.alu_op_in == ALUOP_RTYPE) && (bus.func_in == F_MULT);
  // DONE is excluded so the mult still sitting at the input is not restarted
  assign mult_start = !rst && !bus.flush && is_mult && !mult_busy && !mult_done;
  assign stall      = mult_start || mult_busy;
  assign bubble     = stall || mult_done;

  mult_iter #(.MULT_CYCLES(MULT_CYCLES)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .abort_i (bus.flush),
    .start_i (mult_start),
    .a_i     (op_a),
    .b_i     (op_b),
    .busy_o  (mult_busy),
    .done_o  (mult_done),
    .hi_o    (mult_hi),
    .lo_o    (mult_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (mult_done && !bus.flush) begin
      hi_q <= mult_hi;
      lo_q <= mult_lo;
    end
  end
`else
  assign stall  = 1'b0;
  assign bubble = 1'b0;
`endif

  always_comb begin
    res = '0;
    case (bus.alu_op_in)
      ALUOP_ADD: res = op_a + op_b;
      ALUOP_SUB: res = op_a - op_b;
      ALUOP_OR:  res = op_a | op_b;
      ALUOP_RTYPE: begin
        case (bus.func_in)
          F_ADD:  res = op_a + op_b;
          F_SUB:  res = op_a - op_b;
          F_AND:  res = op_a & op_b;
          F_OR:   res = op_a | op_b;
          F_NOR:  res = ~(op_a | op_b);
          F_SLT:  res = (op_a < op_b) ? W'(1) : '0;
`ifdef EXE_MULT_EN
          F_MFHI: res = hi_q;
          F_MFLO: res = lo_q;
`endif
          default: res = '0;
        endcase
      end
      default: res = '0;
    endcase
  end

  // EX/MEM register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result_q <= '0;
      st_value_q   <= '0;
      dest_q       <= '0;
      mem_r_en_q   <= 1'b0;
      mem_w_en_q   <= 1'b0;
      wb_en_q      <= 1'b0;
      memtoreg_q   <= 1'b0;
    end else begin
      alu_result_q <= res;
      st_value_q   <= st_fwd;
      if (bus.flush || bubble) begin
        dest_q     <= '0;
        mem_r_en_q <= 1'b0;
        mem_w_en_q <= 1'b0;
        wb_en_q    <= 1'b0;
        memtoreg_q <= 1'b0;
      end else begin
        dest_q     <= bus.dest_in;
        mem_r_en_q <= bus.mem_r_en_in;
        mem_w_en_q <= bus.mem_w_en_in;
        wb_en_q    <= bus.wb_en_in;
        memtoreg_q <= bus.memtoreg_in;
      end
    end
  end

  assign bus.alu_result = alu_result_q;
  assign bus.st_value   = st_value_q;
  assign bus.dest       = dest_q;
  assign bus.mem_r_en   = mem_r_en_q;
  assign bus.mem_w_en   = mem_w_en_q;
  assign bus.wb_en      = wb_en_q;
  assign bus.memtoreg   = memtoreg_q;
  assign bus.stall      = stall;

endmodule

// File: tb/tb_exe_mem_stage.sv
// Bench for exe_mem_stage: vector table through a scoreboard queue, plus
// hand sequences for reset, flush and (with EXE_MULT_EN) the multiplier.
module tb_exe_mem_stage;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exe_mem_stage_if bus();
  exe_mem_stage #(.MULT_CYCLES(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string       name;
    logic [31:0] v1, v2, st;
    logic [4:0]  s1, s2, d;
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [3:0]  ctl;   // {mem_r_en, mem_w_en, wb_en, memtoreg}
    logic        v2r;
    logic        mwb;
    logic [4:0]  md;
    logic [31:0] mv;
    logic        wwb;
    logic [4:0]  wd;
    logic [31:0] wv;
    logic [31:0] e_res, e_st;
    logic [4:0]  e_d;
    logic [3:0]  e_ctl;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] res, st;
    logic [4:0]  d;
    logic [3:0]  ctl;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [1:0] op, input logic [5:0] fn,
                              input logic [31:0] a, input logic [31:0] b, input logic v2r,
                              input logic [31:0] er);
    vec_t v;
    v.name = n;   v.op = op;   v.fn = fn;    v.v1 = a;   v.v2 = b;   v.v2r = v2r;
    v.st = 32'h0000_1234;      v.s1 = 5'd1;  v.s2 = 5'd2; v.d = 5'd4; v.ctl = 4'b0010;
    v.mwb = 1'b0; v.md = 5'd0; v.mv = 32'h0;
    v.wwb = 1'b0; v.wd = 5'd0; v.wv = 32'h0;
    v.e_res = er; v.e_st = v.st; v.e_d = v.d; v.e_ctl = v.ctl;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.val1_in = v.v1;  bus.val2_in = v.v2;  bus.st_value_in = v.st;
    bus.src1_in = v.s1;  bus.src2_in = v.s2;  bus.dest_in = v.d;
    bus.alu_op_in = v.op; bus.func_in = v.fn; bus.val2_is_reg_in = v.v2r;
    {bus.mem_r_en_in, bus.mem_w_en_in, bus.wb_en_in, bus.memtoreg_in} = v.ctl;
    bus.mem_fwd_wb_en = v.mwb; bus.mem_fwd_dest = v.md; bus.mem_fwd_value = v.mv;
    bus.wb_fwd_wb_en  = v.wwb; bus.wb_fwd_dest  = v.wd; bus.wb_fwd_value  = v.wv;
  endtask

  function automatic logic [31:0] out_ctl();
    return {28'h0, bus.mem_r_en, bus.mem_w_en, bus.wb_en, bus.memtoreg};
  endfunction

  // Entered and left at a negedge
  task automatic run_vec(input vec_t v);
    exp_t e;
    drive(v);
    e.name = v.name; e.res = v.e_res; e.st = v.e_st; e.d = v.e_d; e.ctl = v.e_ctl;
    sb.push_back(e);
    #1 check({v.name, " stall"}, 32'(bus.stall), 32'h0);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check({e.name, " alu_result"}, bus.alu_result, e.res);
    check({e.name, " st_value"},   bus.st_value,   e.st);
    check({e.name, " dest"},       32'(bus.dest),  32'(e.d));
    check({e.name, " ctl"},        out_ctl(),      32'(e.ctl));
  endtask

`ifdef EXE_MULT_EN
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b);
    vec_t v;
    int   cnt;
    bit   ended;
    v = mk("mult", ALUOP_RTYPE, F_MULT, a, b, 1'b1, 32'h0);
    v.d = 5'd9;
    drive(v);
    cnt = 0;
    ended = 1'b0;
    #1 if (bus.stall) cnt++;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("mult stall-cycle wb_en", 32'(bus.wb_en), 32'h0);
      if (!bus.stall) begin
        ended = 1'b1;
        break;
      end
      cnt++;
    end
    if (!ended) begin
      n_cmp++;
      n_bad++;
      $display("FAIL mult timeout: stall still high after 100 cycles, expected release");
    end
    check("mult stall length", 32'(cnt), 32'd33);
    @(posedge clk);
    @(negedge clk);
    check("mult DONE bubble wb_en", 32'(bus.wb_en), 32'h0);
  endtask
`endif

  initial begin
    vec_t v;

    // Reset with garbage on every input
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.flush = 1'($urandom);
      bus.val1_in = $urandom;  bus.val2_in = $urandom;  bus.st_value_in = $urandom;
      bus.src1_in = 5'($urandom); bus.src2_in = 5'($urandom); bus.dest_in = 5'($urandom);
      bus.alu_op_in = 2'($urandom); bus.func_in = 6'($urandom);
      bus.val2_is_reg_in = 1'($urandom);
      {bus.mem_r_en_in, bus.mem_w_en_in, bus.wb_en_in, bus.memtoreg_in} = 4'($urandom);
      bus.mem_fwd_wb_en = 1'($urandom); bus.mem_fwd_dest = 5'($urandom); bus.mem_fwd_value = $urandom;
      bus.wb_fwd_wb_en  = 1'($urandom); bus.wb_fwd_dest  = 5'($urandom); bus.wb_fwd_value  = $urandom;
      @(posedge clk);
      @(negedge clk);
    end
    bus.alu_op_in = ALUOP_RTYPE;
    bus.func_in   = F_MULT;
    #1;
    check("reset alu_result", bus.alu_result, 32'h0);
    check("reset st_value",   bus.st_value,   32'h0);
    check("reset dest",       32'(bus.dest),  32'h0);
    check("reset ctl",        out_ctl(),      32'h0);
    check("reset stall",      32'(bus.stall), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.flush = 1'b0;

    tbl.push_back(mk("add", ALUOP_RTYPE, F_ADD, 32'd5, 32'd7, 1'b1, 32'd12));
    v = mk("fwd_mem", ALUOP_RTYPE, F_ADD, 32'd1, 32'd1, 1'b0, 32'hAB);
    v.s1 = 5'd3; v.s2 = 5'd0;
    v.mwb = 1'b1; v.md = 5'd3; v.mv = 32'hAA; v.wwb = 1'b1; v.wd = 5'd3; v.wv = 32'hBB;
    tbl.push_back(v);
    v.name = "fwd_src0"; v.s1 = 5'd0; v.md = 5'd0; v.wd = 5'd0; v.e_res = 32'd2;
    tbl.push_back(v);
    v.name = "fwd_wb"; v.s1 = 5'd3; v.md = 5'd3; v.wd = 5'd3; v.mwb = 1'b0; v.e_res = 32'hBC;
    tbl.push_back(v);
    v = mk("fwd_b", ALUOP_RTYPE, F_ADD, 32'd1, 32'h777, 1'b1, 32'h11);
    v.s1 = 5'd0; v.s2 = 5'd5; v.mwb = 1'b1; v.md = 5'd5; v.mv = 32'h10;
    v.st = 32'h99; v.e_st = 32'h10;
    tbl.push_back(v);
    v.name = "imm_b_st_fwd"; v.v2r = 1'b0; v.v2 = 32'd2; v.e_res = 32'd3;
    tbl.push_back(v);
    v = mk("fwd_st_wb", ALUOP_RTYPE, F_ADD, 32'd0, 32'd0, 1'b1, 32'h20);
    v.s1 = 5'd0; v.s2 = 5'd5; v.mwb = 1'b1; v.md = 5'd6; v.mv = 32'h77;
    v.wwb = 1'b1; v.wd = 5'd5; v.wv = 32'h20; v.st = 32'h99; v.e_st = 32'h20;
    tbl.push_back(v);
    tbl.push_back(mk("slt_neg", ALUOP_RTYPE, F_SLT, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd1));
    tbl.push_back(mk("slt_pos", ALUOP_RTYPE, F_SLT, 32'd1, 32'hFFFF_FFFF, 1'b1, 32'd0));
    tbl.push_back(mk("nor", ALUOP_RTYPE, F_NOR, 32'h0F0F_0F0F, 32'h0, 1'b1, 32'hF0F0_F0F0));
    tbl.push_back(mk("and", ALUOP_RTYPE, F_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 32'h0F00_0F00));
    tbl.push_back(mk("or_r", ALUOP_RTYPE, F_OR, 32'h0000_0F00, 32'h0000_00F0, 1'b1, 32'h0000_0FF0));
    tbl.push_back(mk("sub_r", ALUOP_RTYPE, F_SUB, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE));
    v = mk("beq_sub", ALUOP_SUB, F_ADD, 32'd7, 32'd7, 1'b1, 32'd0);
    v.ctl = 4'b0000; v.e_ctl = 4'b0000;
    tbl.push_back(v);
    tbl.push_back(mk("ori", ALUOP_OR, 6'h3F, 32'hF0, 32'h0F, 1'b0, 32'hFF));
    tbl.push_back(mk("add_wrap", ALUOP_ADD, 6'h00, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd1));
    v = mk("lw", ALUOP_ADD, 6'h00, 32'h100, 32'd4, 1'b0, 32'h104);
    v.ctl = 4'b1011; v.e_ctl = 4'b1011; v.d = 5'd17; v.e_d = 5'd17;
    tbl.push_back(v);
    v = mk("sw", ALUOP_ADD, 6'h00, 32'h200, 32'hFFFF_FFFC, 1'b0, 32'h1FC);
    v.ctl = 4'b0100; v.e_ctl = 4'b0100; v.st = 32'hCAFE_F00D; v.e_st = 32'hCAFE_F00D;
    tbl.push_back(v);
    tbl.push_back(mk("bad_func", ALUOP_RTYPE, 6'h3F, 32'd5, 32'd7, 1'b1, 32'd0));
`ifndef EXE_MULT_EN
    tbl.push_back(mk("mult_off", ALUOP_RTYPE, F_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'd0));
    tbl.push_back(mk("mfhi_off", ALUOP_RTYPE, F_MFHI, 32'd5, 32'd7, 1'b1, 32'd0));
    tbl.push_back(mk("mflo_off", ALUOP_RTYPE, F_MFLO, 32'd5, 32'd7, 1'b1, 32'd0));
`endif

    foreach (tbl[i]) run_vec(tbl[i]);

    // Flush turns a live instruction into a bubble
    v = mk("flush_add", ALUOP_RTYPE, F_ADD, 32'd1, 32'd2, 1'b1, 32'd3);
    v.d = 5'd7;
    drive(v);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush wb_en", 32'(bus.wb_en), 32'h0);
    check("flush dest",  32'(bus.dest),  32'h0);

`ifdef EXE_MULT_EN
    do_mult(32'h8000_0000, 32'h8000_0000);
    run_vec(mk("mflo_minmin", ALUOP_RTYPE, F_MFLO, 32'd0, 32'd0, 1'b1, 32'h0000_0000));
    run_vec(mk("mfhi_minmin", ALUOP_RTYPE, F_MFHI, 32'd0, 32'd0, 1'b1, 32'h4000_0000));
    do_mult(32'hFFFF_FFFD, 32'd7);
    run_vec(mk("mflo_m3x7", ALUOP_RTYPE, F_MFLO, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFEB));
    run_vec(mk("mfhi_m3x7", ALUOP_RTYPE, F_MFHI, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF));

    // Abort a 2x2 multiply at BUSY cycle 10; HI/LO must keep -21
    v = mk("mult_abort", ALUOP_RTYPE, F_MULT, 32'd2, 32'd2, 1'b1, 32'h0);
    drive(v);
    #1 check("mult_abort start stall", 32'(bus.stall), 32'h1);
    for (int i = 0; i < 11; i++) @(posedge clk);
    @(negedge clk);
    check("mult_abort busy stall", 32'(bus.stall), 32'h1);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    check("mult_abort wb_en", 32'(bus.wb_en), 32'h0);
    run_vec(mk("mflo_after_abort", ALUOP_RTYPE, F_MFLO, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFEB));
    run_vec(mk("mfhi_after_abort", ALUOP_RTYPE, F_MFHI, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
